// File: rtl/round_pipe_unit.sv
// Two-stage rounding/normalisation pipeline for the multiplier datapath.
// Stage 1 normalises and selects the kept/guard/sticky bits. Stage 2 rounds, resolves overflow and drives out_*.
module round_pipe_unit #(
    parameter int MANT_WIDTH = 24,
    parameter int EXP_WIDTH  = 8,
    parameter int PROD_WIDTH = 2 * MANT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PROD_WIDTH-1:0] in_prod,
    input  logic [EXP_WIDTH-1:0]  in_exp,
    input  logic                  in_sign,
    input  logic [2:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [EXP_WIDTH-1:0]  out_exp,
    output logic [MANT_WIDTH-2:0] out_frac,
    output logic                  out_inexact,
    output logic                  out_overflow,
    output logic [1:0]            acc_flags,
    input  logic                  flags_clr
);
    localparam int M = MANT_WIDTH;
    localparam int E = EXP_WIDTH;
    localparam logic [E:0] EXP_ALL_ONES = {1'b0, {E{1'b1}}};

    typedef enum logic [2:0] {
        MODE_RNE = 3'b000,
        MODE_RTZ = 3'b001,
        MODE_RUP = 3'b010,
        MODE_RDN = 3'b011,
        MODE_RMM = 3'b100
    } roundMode_e;

    logic            s1Valid_q;
    logic [M-2:0]    s1Frac_q, s1Frac_d;
    logic            s1Guard_q, s1Guard_d;
    logic            s1Sticky_q, s1Sticky_d;
    logic [E:0]      s1Exp_q, s1Exp_d;
    logic            s1Sign_q;
    logic [2:0]      s1Mode_q;

    logic            outValid_q;
    logic            outSign_q;
    logic [E-1:0]    outExp_q, outExp_d;
    logic [M-2:0]    outFrac_q, outFrac_d;
    logic            outInexact_q, outOverflow_q;
    logic [1:0]      accFlags_q;

    logic            s2Ready, s1Advance, outFire;
    logic            gs, inc, toInf, ovf;
    logic [M-1:0]    sum;
    logic [E:0]      expRnd;

    assign s2Ready   = ~outValid_q | out_ready;
    assign s1Advance = ~s1Valid_q | s2Ready;
    assign outFire   = outValid_q & out_ready;
    assign in_ready  = s1Advance;

    // The hidden bit is 1 for any in-contract product, so only the fraction is carried forward.
    always_comb begin
        if (in_prod[2*M-1]) begin
            s1Frac_d   = in_prod[2*M-2:M];
            s1Guard_d  = in_prod[M-1];
            s1Sticky_d = |in_prod[M-2:0];
            s1Exp_d    = {1'b0, in_exp} + {{E{1'b0}}, 1'b1};
        end else begin
            s1Frac_d   = in_prod[2*M-3:M-1];
            s1Guard_d  = in_prod[M-2];
            s1Sticky_d = |in_prod[M-3:0];
            s1Exp_d    = {1'b0, in_exp};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q  <= 1'b0;
            s1Frac_q   <= '0;
            s1Guard_q  <= 1'b0;
            s1Sticky_q <= 1'b0;
            s1Exp_q    <= '0;
            s1Sign_q   <= 1'b0;
            s1Mode_q   <= '0;
        end else if (s1Advance) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                s1Frac_q   <= s1Frac_d;
                s1Guard_q  <= s1Guard_d;
                s1Sticky_q <= s1Sticky_d;
                s1Exp_q    <= s1Exp_d;
                s1Sign_q   <= in_sign;
                s1Mode_q   <= in_mode;
            end
        end
    end

    assign gs = s1Guard_q | s1Sticky_q;

    // Unlisted mode codes fall into the default arm and behave as RNE.
    always_comb begin
        inc   = 1'b0;
        toInf = 1'b1;
        case (roundMode_e'(s1Mode_q))
            MODE_RTZ: begin inc = 1'b0;             toInf = 1'b0;      end
            MODE_RUP: begin inc = ~s1Sign_q & gs;   toInf = ~s1Sign_q; end
            MODE_RDN: begin inc = s1Sign_q & gs;    toInf = s1Sign_q;  end
            MODE_RMM: begin inc = s1Guard_q;        toInf = 1'b1;      end
            default:  begin inc = s1Guard_q & (s1Sticky_q | s1Frac_q[0]); toInf = 1'b1; end
        endcase
    end

    // A carry out of the fraction leaves it all zeros, which is exactly the renormalised 1.000 mantissa.
    assign sum    = {1'b0, s1Frac_q} + {{(M-1){1'b0}}, inc};
    assign expRnd = s1Exp_q + {{E{1'b0}}, sum[M-1]};
    assign ovf    = expRnd >= EXP_ALL_ONES;

    always_comb begin
        if (ovf && toInf) begin
            outExp_d  = {E{1'b1}};
            outFrac_d = '0;
        end else if (ovf) begin
            outExp_d  = {{(E-1){1'b1}}, 1'b0};
            outFrac_d = {(M-1){1'b1}};
        end else begin
            outExp_d  = expRnd[E-1:0];
            outFrac_d = sum[M-2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q    <= 1'b0;
            outSign_q     <= 1'b0;
            outExp_q      <= '0;
            outFrac_q     <= '0;
            outInexact_q  <= 1'b0;
            outOverflow_q <= 1'b0;
        end else if (s2Ready) begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                outSign_q     <= s1Sign_q;
                outExp_q      <= outExp_d;
                outFrac_q     <= outFrac_d;
                outInexact_q  <= gs | ovf;
                outOverflow_q <= ovf;
            end
        end
    end

    // A clear coinciding with a handshake drops the history but keeps that beat's flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accFlags_q <= 2'b00;
        end else if (outFire) begin
            accFlags_q <= flags_clr ? {outOverflow_q, outInexact_q}
                                    : accFlags_q | {outOverflow_q, outInexact_q};
        end else if (flags_clr) begin
            accFlags_q <= 2'b00;
        end
    end

    assign out_valid    = outValid_q;
    assign out_sign     = outSign_q;
    assign out_exp      = outExp_q;
    assign out_frac     = outFrac_q;
    assign out_inexact  = outInexact_q;
    assign out_overflow = outOverflow_q;
    assign acc_flags    = accFlags_q;
endmodule

// File: tb/tb_round_pipe_unit.sv
// Bench for round_pipe_unit: a table of hand-derived vectors feeds a scoreboard queue that is
// checked whenever out_valid is high, plus directed sequences for latency, backpressure, reset and flags.
module tb_round_pipe_unit;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_prod;
    logic [7:0]  in_exp;
    logic        in_sign;
    logic [2:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic        out_inexact;
    logic        out_overflow;
    logic [1:0]  acc_flags;
    logic        flags_clr;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic        inexact;
        logic        overflow;
    } res_t;

    typedef struct packed {
        logic        sign;
        logic [2:0]  mode;
        logic [47:0] prod;
        logic [7:0]  expIn;
        res_t        want;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];
    res_t curExp;
    vec_t vecs[22];

    round_pipe_unit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_exp(in_exp), .in_sign(in_sign), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
        .out_inexact(out_inexact), .out_overflow(out_overflow),
        .acc_flags(acc_flags), .flags_clr(flags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic [2:0] m, input logic [47:0] p,
                                input logic [7:0] e, input logic [7:0] ee, input logic [22:0] ef,
                                input logic ei, input logic eo);
        vec_t v;
        v.sign = s;
        v.mode = m;
        v.prod = p;
        v.expIn = e;
        v.want.sign = s;
        v.want.exp = ee;
        v.want.frac = ef;
        v.want.inexact = ei;
        v.want.overflow = eo;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic driveBeat(input vec_t v);
        in_sign  = v.sign;
        in_mode  = v.mode;
        in_prod  = v.prod;
        in_exp   = v.expIn;
        curExp   = v.want;
        in_valid = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic applyStimulus(input vec_t v);
        int n = 0;
        driveBeat(v);
        #4;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #4;
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic waitOutValid();
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) checkOutput("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    // Sample just before each posedge: push accepted beats, compare whatever is presented.
    initial begin
        res_t got;
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                if (in_valid && in_ready) sb.push_back(curExp);
                if (out_valid) begin
                    got = {out_sign, out_exp, out_frac, out_inexact, out_overflow};
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_out", 64'(out_valid), 64'd0);
                    end else begin
                        checkOutput(out_ready ? "beat" : "beat_held", 64'(got), 64'(sb[0]));
                        if (out_ready) void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int idx;
        vecs[0]  = mk(0, 3'd0, 48'h400000000000, 8'd127, 8'd127, 23'h000000, 0, 0);
        vecs[1]  = mk(0, 3'd0, 48'h400000400000, 8'd127, 8'd127, 23'h000000, 1, 0);
        vecs[2]  = mk(0, 3'd0, 48'h400000C00000, 8'd127, 8'd127, 23'h000002, 1, 0);
        vecs[3]  = mk(0, 3'd4, 48'h400000400000, 8'd127, 8'd127, 23'h000001, 1, 0);
        vecs[4]  = mk(0, 3'd0, 48'h7FFFFFC00000, 8'd127, 8'd128, 23'h000000, 1, 0);
        vecs[5]  = mk(0, 3'd1, 48'h7FFFFFC00000, 8'd127, 8'd127, 23'h7FFFFF, 1, 0);
        vecs[6]  = mk(0, 3'd0, 48'h800000000000, 8'd254, 8'hFF,  23'h000000, 1, 1);
        vecs[7]  = mk(0, 3'd1, 48'h800000000000, 8'd254, 8'hFE,  23'h7FFFFF, 1, 1);
        vecs[8]  = mk(1, 3'd3, 48'h800000000000, 8'd254, 8'hFF,  23'h000000, 1, 1);
        vecs[9]  = mk(1, 3'd2, 48'h800000000000, 8'd254, 8'hFE,  23'h7FFFFF, 1, 1);
        vecs[10] = mk(0, 3'd0, 48'h800000000000, 8'd100, 8'd101, 23'h000000, 0, 0);
        vecs[11] = mk(0, 3'd2, 48'h400000000001, 8'd10,  8'd10,  23'h000001, 1, 0);
        vecs[12] = mk(0, 3'd3, 48'h400000000001, 8'd10,  8'd10,  23'h000000, 1, 0);
        vecs[13] = mk(1, 3'd3, 48'h400000000001, 8'd10,  8'd10,  23'h000001, 1, 0);
        vecs[14] = mk(0, 3'd7, 48'h400000600000, 8'd50,  8'd50,  23'h000001, 1, 0);
        vecs[15] = mk(0, 3'd0, 48'hC00000800000, 8'd1,   8'd2,   23'h400000, 1, 0);
        vecs[16] = mk(1, 3'd4, 48'hC00000800000, 8'd1,   8'd2,   23'h400001, 1, 0);
        vecs[17] = mk(0, 3'd2, 48'h800000000000, 8'd254, 8'hFF,  23'h000000, 1, 1);
        vecs[18] = mk(1, 3'd4, 48'h800000000000, 8'd254, 8'hFF,  23'h000000, 1, 1);
        vecs[19] = mk(0, 3'd0, 48'h7FFFFFC00000, 8'd254, 8'hFF,  23'h000000, 1, 1);
        vecs[20] = mk(0, 3'd1, 48'h7FFFFFC00000, 8'd254, 8'hFE,  23'h7FFFFF, 1, 0);
        vecs[21] = mk(0, 3'd0, 48'h800000000000, 8'd253, 8'hFE,  23'h000000, 0, 0);

        rst = 1'b1;
        in_valid = 1'b0;
        in_prod = '0;
        in_exp = '0;
        in_sign = 1'b0;
        in_mode = '0;
        out_ready = 1'b1;
        flags_clr = 1'b0;
        curExp = '0;

        #12;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_acc_flags", 64'(acc_flags), 64'd0);
        checkOutput("rst_out_data", 64'({out_exp, out_frac, out_inexact, out_overflow}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] latency");
        @(negedge clk);
        applyStimulus(vecs[0]);
        #1;
        checkOutput("latency_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("latency_cycle2", 64'(out_valid), 64'd1);
        @(negedge clk);

        $display("[TB] vector table");
        for (int i = 0; i < 22; i++) applyStimulus(vecs[i]);
        waitDrain();
        #1;
        checkOutput("acc_after_table", 64'(acc_flags), 64'd3);
        @(negedge clk);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        #1;
        checkOutput("acc_clr_alone", 64'(acc_flags), 64'd0);

        $display("[TB] backpressure");
        @(negedge clk);
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 4) driveBeat(vecs[11 + idx]);
            else in_valid = 1'b0;
            #4;
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        checkOutput("bp_accepted", 64'(idx), 64'd2);
        #1;
        checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        while (idx < 4) begin
            applyStimulus(vecs[11 + idx]);
            idx++;
        end
        waitDrain();

        $display("[TB] reset mid-stall");
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(vecs[1]);
        applyStimulus(vecs[2]);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_acc_flags", 64'(acc_flags), 64'd0);
        checkOutput("midrst_out_data", 64'({out_sign, out_exp, out_frac}), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_out_valid_after", 64'(out_valid), 64'd0);

        $display("[TB] flags");
        @(negedge clk);
        out_ready = 1'b1;
        applyStimulus(vecs[1]);
        waitDrain();
        #1;
        checkOutput("acc_inexact", 64'(acc_flags), 64'd1);

        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(vecs[0]);
        waitOutValid();
        out_ready = 1'b1;
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        #1;
        checkOutput("acc_clr_hs_exact", 64'(acc_flags), 64'd0);

        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(vecs[6]);
        waitOutValid();
        out_ready = 1'b1;
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        #1;
        checkOutput("acc_clr_hs_ovf", 64'(acc_flags), 64'd3);

        @(negedge clk);
        applyStimulus(vecs[0]);
        waitDrain();
        #1;
        checkOutput("acc_sticky", 64'(acc_flags), 64'd3);
        @(negedge clk);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        #1;
        checkOutput("acc_clr_alone2", 64'(acc_flags), 64'd0);

        @(negedge clk);
        checkOutput("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/round_pipe_unit.md
Name: round_pipe_unit

Overview:
- Two-stage pipelined rounding and normalisation unit for the multiplier datapath.
- Takes the raw double-width mantissa product, sign and pre-biased exponent.
- Normalises the product by at most one bit, then rounds in one of five run-time-selectable IEEE modes and resolves exponent overflow per mode.
- Sits between the mantissa multiplier array and result packing, with valid/ready flow control on both sides and an accumulated exception-flag register.

Parameters:
- MANT_WIDTH, 24, mantissa width including hidden bit (53 for double).
- EXP_WIDTH, 8, biased exponent width (11 for double).
- PROD_WIDTH, 2*MANT_WIDTH, product input width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- in_prod  in  PROD_WIDTH  unsigned mantissa product, value in [1,4).
- in_exp  in  EXP_WIDTH  biased exponent before normalisation, 1..2^EXP_WIDTH-2.
- in_sign  in  1  result sign.
- in_mode  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RUP (+inf), 011 RDN (-inf), 100 RMM (nearest, ties away); 101-111 treated as RNE.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_sign  out  1  result sign.
- out_exp  out  EXP_WIDTH  final biased exponent.
- out_frac  out  MANT_WIDTH-1  fraction with hidden bit dropped.
- out_inexact  out  1  guard or sticky was nonzero.
- out_overflow  out  1  result exponent reached all-ones.
- acc_flags  out  2  sticky {overflow, inexact}, ORed over every output handshake.
- flags_clr  in  1  clears acc_flags.

Behaviour:
- **Handshakes.** A beat transfers on in_valid&in_ready; a result transfers on out_valid&out_ready.
- **Throughput and latency.** Throughput is 1 beat/cycle. Latency is exactly 2 cycles from accept to out_valid when unstalled.
- **Stall rules.**
  - s2_ready = ~s2_valid | out_ready.
  - s1 advances when ~s1_valid | s2_ready.
  - in_ready = ~s1_valid | s2_ready.
  - out_* are held stable while out_valid & ~out_ready. No beat is lost or duplicated under any valid/ready pattern.
- **Stage 1 (normalise, select bits).** M = MANT_WIDTH.
  - If in_prod[2M-1]=1: kept = prod[2M-1:M], guard = prod[M-1], sticky = |prod[M-2:0], exp = in_exp+1.
  - Else: kept = prod[2M-2:M-1], guard = prod[M-2], sticky = |prod[M-3:0], exp = in_exp.
  - The exponent is carried internally at EXP_WIDTH+1 bits; it never wraps.
  - Mode, sign and these bits are registered into stage 2.
- **Increment per mode.** lsb = kept[0], gs = guard|sticky.
  - RNE: guard&(sticky|lsb).
  - RTZ: 0.
  - RUP: ~sign&gs.
  - RDN: sign&gs.
  - RMM: guard.
- **Stage 2 (round, resolve).**
  - sum = kept+inc, computed at M+1 bits.
  - If sum[M]=1: mantissa = 1 followed by zeros, exp+1.
  - overflow = (exp >= 2^EXP_WIDTH-1).
  - inexact = gs | overflow.
- **Overflow result per mode.**
  - RNE and RMM: infinity (exp all ones, frac 0).
  - RTZ: max finite (exp all-ones minus 1, frac all ones).
  - RUP: infinity if positive, else max finite.
  - RDN: infinity if negative, else max finite.
- **acc_flags.** Sets on each output handshake from that beat's flags. On flags_clr in the same cycle as a handshake, the register takes that beat's flags only; clear of older history wins, new flags are kept. flags_clr alone sets the register to 0.
- **Out of scope.** Underflow and subnormals are not handled; in_exp=0 or all-ones is an input contract violation with unspecified output.
- **Reset.** Asynchronous, any cycle including mid-stall. Clears all valids, out_* data, out flags and acc_flags to 0. in_ready is 1 in the first cycle after reset deasserts. In-flight beats are discarded.

Test Plan:
- **Exact, no normalise.** M=24, E=8: prod=0x400000000000, exp=127, RNE, out_ready=1 -> out_valid 2 cycles after accept; exp=127, frac=0, inexact=0, overflow=0.
- **Tie to even.** prod=0x400000400000 (guard=1, sticky=0, lsb=0), RNE -> frac=0, inexact=1. Same with prod=0x400000C00000 -> frac=0x000002. RMM on the first stimulus -> frac=0x000001.
- **Carry-out.** prod=0x7FFFFFC00000, exp=127, RNE -> exp=128, frac=0, inexact=1. Same stimulus in RTZ -> exp=127, frac=0x7FFFFF.
- **Overflow.** prod=0x800000000000, exp=254, RNE -> exp=0xFF, frac=0, overflow=1. RTZ -> exp=0xFE, frac=0x7FFFFF, overflow=1. RDN with sign=1 -> infinity. RUP with sign=1 -> max finite.
- **Backpressure.** Hold out_ready=0 for 5 cycles while feeding 4 beats back-to-back -> in_ready drops after 2 accepted beats and out_* stay stable. Release -> all beats emerge in order, none dropped or duplicated.
- **Reset and flags.** Assert rst mid-stall -> out_valid=0 and acc_flags=0 immediately. Then send an inexact beat -> acc_flags=01. Pulse flags_clr alone -> acc_flags=00.
